tpu_c_drain: RTL and testbench
==============================

TPU_C_DRAIN -- requirements
Module: tpu_c_drain

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, output-buffer entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to drain a finished C matrix.
REQ-005 SHALL have port M  input  8  rows of C, sampled on accepted start.
REQ-006 SHALL have port N  input  8  columns of C, sampled on accepted start.
REQ-007 SHALL have port shift  input  5  requantize right-shift, sampled on accepted start.
REQ-008 SHALL have port busy  output  1  high from accepted start until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse when drain completes.
REQ-010 SHALL have ports C_wr_en  output  1, C_index  output  16 and C_data_in  output  128: C SRAM read port; C_wr_en and C_data_in tied 0.
REQ-011 SHALL have port C_data_out  input  128  SRAM read data, valid one cycle after C_index.
REQ-012 SHALL have ports out_valid  output  1 and out_ready  input  1: output stream handshake.
REQ-013 SHALL have ports out_data  output  32, out_keep  output  4 and out_last  output  1: four int8 results, byte enables, final-beat flag.

Function
REQ-014 Start accepted only in IDLE; start while busy SHALL be ignored.
REQ-015 States: IDLE, READ (issuing reads), DRAIN (no reads left, buffer emptying), DONE (one cycle, done=1) -> IDLE.
REQ-016 NT = ceil(N/4); reads SHALL be issued row-major: r = 0..M-1 outer, t = 0..NT-1 inner; C_index = t*M + r, 16-bit.
REQ-017 Word layout: C_data_out[127:96] = C[r][4t], [95:64] = C[r][4t+1], [63:32] = C[r][4t+2], [31:0] = C[r][4t+3], all unsigned 32-bit.
REQ-018 Per element: q = min((x + R) >> shift, 255), R = 0 if shift==0 else 1<<(shift-1); addition 33 bits wide, no wrap.
REQ-019 out_data[31:24] = q of [127:96] ... out_data[7:0] = q of [31:0].
REQ-020 out_keep = 4'b1111 except t==NT-1: N%4 = 1 -> 1000, 2 -> 1100, 3 -> 1110, 0 -> 1111; disabled bytes SHALL be 0.
REQ-021 out_last = 1 only on beat r==M-1, t==NT-1.
REQ-022 Read issued in a cycle only if (buffer occupancy + reads in flight) < FIFO_DEPTH; never drops or duplicates a beat.
REQ-023 Beat transfers when out_valid && out_ready; out_valid, out_data, out_keep, out_last SHALL hold stable while out_valid && !out_ready.
REQ-024 Simultaneous buffer push and pop SHALL be allowed; with out_ready held high, one beat per cycle sustained after 2-cycle first-beat latency (start at cycle 0 -> first out_valid at cycle 2).
REQ-025 READ -> DRAIN after last read issued; DRAIN -> DONE in the cycle after the beat with out_last transfers; busy falls together with done.
REQ-026 Start with M==0 or N==0: no reads, no beats; DONE next cycle.
REQ-027 C_index SHALL be 0 outside READ.

Reset
REQ-028 On rst_n low (any time, including mid-drain): state IDLE, busy 0, done 0, out_valid 0, out_last 0, out_keep 0, out_data 0, C_index 0, buffer emptied, counters 0.
REQ-029 After reset release, no beat of an aborted drain SHALL appear; next start begins from r=0, t=0.

Verification
REQ-030 M=4, N=4, shift=0, C words {1,2,3,4}.. per row, out_ready=1 -> 4 beats, out_data=0x01020304 on row 0, keep 1111, last on beat 4, done cycle after.
REQ-031 M=5, N=6, shift=0 -> 10 beats, indices 0,5,1,6,2,7,3,8,4,9; keep alternates 1111/1100; last on index 9.
REQ-032 shift=4, element 0x18 -> 0x02 (rounds up 1.5); element 0xFFFFFFFF -> 0xFF, no overflow wrap.
REQ-033 out_ready toggled randomly, M=8, N=8 -> 16 beats in order, data stable during stall, occupancy never exceeds FIFO_DEPTH.
REQ-034 Start with N=0 -> done one cycle after start, out_valid never asserted; start pulsed while busy -> ignored.
REQ-035 rst_n low mid-drain for 1 cycle -> all outputs 0 immediately; fresh start M=4, N=4 yields exactly 4 beats.

Source files
------------

// File: rtl/tpu_c_drain.sv
// tpu_c_drain: streams a finished C matrix from SRAM as requantized int8 beats (start/busy/done control, C_* SRAM read port, out_* valid/ready stream)
module tpu_c_drain #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [7:0]   M,
  input  logic [7:0]   N,
  input  logic [4:0]   shift,
  output logic         busy,
  output logic         done,
  output logic         C_wr_en,
  output logic [15:0]  C_index,
  output logic [127:0] C_data_in,
  input  logic [127:0] C_data_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic [3:0]   out_keep,
  output logic         out_last
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state;
  logic [7:0] m_q, nt_q, r, t;
  logic [1:0] n_lo;
  logic [4:0] sh_q;
  logic fl, fl_last;
  logic [3:0] fl_keep;
  logic [36:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic [CW:0] occ;
  logic pop, iss, last_t, last_rd;
  logic [3:0] keep_t;
  logic [31:0] qd;
  logic [36:0] head;

  function automatic logic [7:0] q8(input logic [31:0] x, input logic [4:0] s);
    logic [32:0] sum;
    sum = ({1'b0, x} + (s == 5'd0 ? 33'd0 : 33'd1 << (s - 5'd1))) >> s;
    return |sum[32:8] ? 8'hff : sum[7:0];
  endfunction

  assign head = mem[rp];
  assign out_valid = cnt != '0;
  assign {out_data, out_keep, out_last} = out_valid ? head : '0;
  assign pop = out_valid && out_ready;
  assign occ = {1'b0, cnt} + {{CW{1'b0}}, fl} - {{CW{1'b0}}, pop};
  assign iss = state == READ && occ < (CW+1)'(FIFO_DEPTH);
  assign last_t = t == nt_q - 8'd1;
  assign last_rd = last_t && r == m_q - 8'd1;
  assign keep_t = !last_t || n_lo == 2'd0 ? 4'b1111 : n_lo == 2'd1 ? 4'b1000 : n_lo == 2'd2 ? 4'b1100 : 4'b1110;
  assign qd = {fl_keep[3] ? q8(C_data_out[127:96], sh_q) : 8'd0,
               fl_keep[2] ? q8(C_data_out[95:64], sh_q) : 8'd0,
               fl_keep[1] ? q8(C_data_out[63:32], sh_q) : 8'd0,
               fl_keep[0] ? q8(C_data_out[31:0], sh_q) : 8'd0};
  assign C_index = state == READ ? {8'd0, t} * {8'd0, m_q} + {8'd0, r} : '0;
  assign C_wr_en = 1'b0;
  assign C_data_in = '0;
  assign busy = state == READ || state == DRAIN;
  assign done = state == DONE;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      m_q <= '0;
      nt_q <= '0;
      n_lo <= '0;
      sh_q <= '0;
      r <= '0;
      t <= '0;
      fl <= 1'b0;
      fl_keep <= '0;
      fl_last <= 1'b0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      fl <= iss;
      fl_keep <= keep_t;
      fl_last <= last_rd;
      wp <= wp + AW'(fl);
      rp <= rp + AW'(pop);
      cnt <= cnt + CW'(fl) - CW'(pop);
      case (state)
        IDLE: if (start) begin
          m_q <= M;
          n_lo <= N[1:0];
          sh_q <= shift;
          nt_q <= 8'((9'(N) + 9'd3) >> 2);
          r <= '0;
          t <= '0;
          state <= M == 8'd0 || N == 8'd0 ? DONE : READ;
        end
        READ: if (iss) begin
          state <= last_rd ? DRAIN : READ;
          r <= last_t ? r + 8'd1 : r;
          t <= last_t ? '0 : t + 8'd1;
        end
        DRAIN: if (pop && out_last) state <= DONE;
        default: state <= IDLE;
      endcase
    end

  always_ff @(posedge clk)
    if (fl) mem[wp] <= {qd, fl_keep, fl_last};
endmodule

// File: tb/tb_tpu_c_drain.sv
// tb_tpu_c_drain: directed self-checking bench for tpu_c_drain
module tb_tpu_c_drain;
  logic clk = 0, rst_n = 0, start = 0, out_ready = 1;
  logic [7:0] M = 0, N = 0;
  logic [4:0] shift = 0;
  logic busy, done, C_wr_en, out_valid, out_last;
  logic [15:0] C_index;
  logic [127:0] C_data_in, C_data_out;
  logic [31:0] out_data;
  logic [3:0] out_keep;
  logic [127:0] sram [0:255];
  logic [36:0] beats [$];
  int total = 0, bad = 0;
  int first_v, done_c;
  logic busy0;

  tpu_c_drain #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .M(M), .N(N), .shift(shift),
    .busy(busy), .done(done), .C_wr_en(C_wr_en), .C_index(C_index),
    .C_data_in(C_data_in), .C_data_out(C_data_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_keep(out_keep), .out_last(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) C_data_out <= sram[C_index[7:0]];

  task automatic run(input logic [7:0] m, input logic [7:0] n, input logic [4:0] sh, input bit rnd, input int restart_at);
    logic [36:0] prev;
    bit hold;
    hold = 0;
    prev = '0;
    beats.delete();
    first_v = -1;
    done_c = -1;
    @(negedge clk);
    M = m;
    N = n;
    shift = sh;
    start = 1;
    out_ready = 1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      start = (c == restart_at);
      if (c == restart_at) begin
        M = 8'd2;
        N = 8'd8;
      end
      if (c == 0) busy0 = busy;
      if (out_valid && first_v < 0) first_v = c;
      if (hold) begin
        total++;
        if ({out_valid, out_data, out_keep, out_last} !== {1'b1, prev}) begin
          bad++;
          $display("FAIL stall_hold c=%0d got %b_%h_%b_%b want 1_%h", c, out_valid, out_data, out_keep, out_last, prev);
        end
      end
      if (done) begin
        done_c = c;
        break;
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      hold = out_valid && !out_ready;
      prev = {out_data, out_keep, out_last};
      if (out_valid && out_ready) beats.push_back({out_data, out_keep, out_last});
    end
    start = 0;
    out_ready = 1;
    if (done_c < 0) begin
      total++;
      bad++;
      $display("FAIL timeout got no done want done within 600 cycles");
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({busy, done, out_valid, out_last, out_keep, out_data, C_index, C_wr_en, C_data_in} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b done=%b v=%b idx=%h data=%h", busy, done, out_valid, C_index, out_data);
    end
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    total++;
    if ({busy, done, out_valid, C_index, C_wr_en} !== '0) begin
      bad++;
      $display("FAIL idle_outputs got busy=%b done=%b v=%b idx=%h", busy, done, out_valid, C_index);
    end
  endtask

  task automatic test_basic();
    logic [31:0] e [4] = '{32'h01020304, 32'h05060708, 32'h090a0b0c, 32'h0d0e0f10};
    for (int r = 0; r < 4; r++) sram[r] = {32'(4*r+1), 32'(4*r+2), 32'(4*r+3), 32'(4*r+4)};
    run(8'd4, 8'd4, 5'd0, 0, -1);
    total++;
    if (busy0 !== 1'b1) begin bad++; $display("FAIL basic_busy got %b want 1", busy0); end
    total++;
    if (first_v != 2) begin bad++; $display("FAIL basic_latency got %0d want 2", first_v); end
    total++;
    if (beats.size() != 4) begin bad++; $display("FAIL basic_count got %0d want 4", beats.size()); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (beats[k] !== {e[k], 4'b1111, k == 3}) begin bad++; $display("FAIL basic_beat[%0d] got %h want %h", k, beats[k], {e[k], 4'b1111, k == 3}); end
    end
    total++;
    if (done_c != 6) begin bad++; $display("FAIL basic_done_cycle got %0d want 6", done_c); end
    @(negedge clk);
    total++;
    if ({done, busy} !== 2'b00) begin bad++; $display("FAIL done_pulse got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_tiles();
    int idx [10] = '{0, 5, 1, 6, 2, 7, 3, 8, 4, 9};
    logic [31:0] d;
    logic [36:0] ex;
    for (int i = 0; i < 10; i++) sram[i] = {32'(i), 32'(i+16), 32'(i+32), 32'(i+48)};
    run(8'd5, 8'd6, 5'd0, 0, -1);
    total++;
    if (beats.size() != 10) begin bad++; $display("FAIL tiles_count got %0d want 10", beats.size()); end
    for (int k = 0; k < 10; k++) begin
      d = {8'(idx[k]), 8'(idx[k]+16), 8'(idx[k]+32), 8'(idx[k]+48)};
      if (k % 2 == 1) d[15:0] = '0;
      ex = {d, k % 2 == 1 ? 4'b1100 : 4'b1111, k == 9};
      total++;
      if (beats[k] !== ex) begin bad++; $display("FAIL tiles_beat[%0d] got %h want %h", k, beats[k], ex); end
    end
    total++;
    if (done_c != 12) begin bad++; $display("FAIL tiles_done_cycle got %0d want 12", done_c); end
  endtask

  task automatic test_quant();
    logic [127:0] w [3] = '{{32'h18, 32'hffffffff, 32'h17, 32'h08},
                            {32'h100, 32'hff, 32'h7, 32'h55},
                            {32'hffffffff, 32'h40000000, 32'h3fffffff, 32'h0}};
    logic [7:0] n [3] = '{8'd4, 8'd3, 8'd4};
    logic [4:0] s [3] = '{5'd4, 5'd0, 5'd31};
    logic [36:0] ex [3] = '{{32'h02ff0101, 4'b1111, 1'b1},
                            {32'hffff0700, 4'b1110, 1'b1},
                            {32'h02010000, 4'b1111, 1'b1}};
    for (int j = 0; j < 3; j++) begin
      sram[0] = w[j];
      run(8'd1, n[j], s[j], 0, -1);
      total++;
      if (beats.size() != 1 || beats[0] !== ex[j]) begin
        bad++;
        $display("FAIL quant[%0d] got n=%0d beat=%h want 1 beat %h", j, beats.size(), beats[0], ex[j]);
      end
    end
  endtask

  task automatic test_backpressure();
    int idx [16] = '{0, 8, 1, 9, 2, 10, 3, 11, 4, 12, 5, 13, 6, 14, 7, 15};
    logic [36:0] ex;
    for (int i = 0; i < 16; i++) sram[i] = {32'(i), 32'(i+64), 32'(i+128), 32'(i+192)};
    run(8'd8, 8'd8, 5'd0, 1, -1);
    total++;
    if (beats.size() != 16) begin bad++; $display("FAIL bp_count got %0d want 16", beats.size()); end
    for (int k = 0; k < 16; k++) begin
      ex = {8'(idx[k]), 8'(idx[k]+64), 8'(idx[k]+128), 8'(idx[k]+192), 4'b1111, k == 15};
      total++;
      if (beats[k] !== ex) begin bad++; $display("FAIL bp_beat[%0d] got %h want %h", k, beats[k], ex); end
    end
  endtask

  task automatic test_empty_and_ignore();
    logic [31:0] e [4] = '{32'h01020304, 32'h05060708, 32'h090a0b0c, 32'h0d0e0f10};
    run(8'd4, 8'd0, 5'd0, 0, -1);
    total++;
    if (done_c != 0 || first_v != -1 || beats.size() != 0 || busy0 !== 1'b0) begin
      bad++;
      $display("FAIL empty_n got done_c=%0d first_v=%0d beats=%0d busy=%b want 0 -1 0 0", done_c, first_v, beats.size(), busy0);
    end
    run(8'd0, 8'd4, 5'd0, 0, -1);
    total++;
    if (done_c != 0 || beats.size() != 0) begin
      bad++;
      $display("FAIL empty_m got done_c=%0d beats=%0d want 0 0", done_c, beats.size());
    end
    for (int r = 0; r < 4; r++) sram[r] = {32'(4*r+1), 32'(4*r+2), 32'(4*r+3), 32'(4*r+4)};
    run(8'd4, 8'd4, 5'd0, 0, 2);
    total++;
    if (beats.size() != 4 || done_c != 6) begin
      bad++;
      $display("FAIL ignore_start got beats=%0d done_c=%0d want 4 6", beats.size(), done_c);
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (beats[k] !== {e[k], 4'b1111, k == 3}) begin bad++; $display("FAIL ignore_beat[%0d] got %h want %h", k, beats[k], {e[k], 4'b1111, k == 3}); end
    end
  endtask

  task automatic test_abort();
    logic [31:0] e [4] = '{32'h21222324, 32'h25262728, 32'h292a2b2c, 32'h2d2e2f30};
    for (int r = 0; r < 4; r++) sram[r] = {32'(4*r+1), 32'(4*r+2), 32'(4*r+3), 32'(4*r+4)};
    @(negedge clk);
    M = 8'd4;
    N = 8'd4;
    shift = 5'd0;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
    rst_n = 0;
    #1;
    total++;
    if ({busy, done, out_valid, out_last, out_keep, out_data, C_index} !== '0) begin
      bad++;
      $display("FAIL abort_outputs got busy=%b v=%b data=%h keep=%b idx=%h want all 0", busy, out_valid, out_data, out_keep, C_index);
    end
    @(negedge clk);
    rst_n = 1;
    for (int r = 0; r < 4; r++) sram[r] = {32'(4*r+33), 32'(4*r+34), 32'(4*r+35), 32'(4*r+36)};
    run(8'd4, 8'd4, 5'd0, 0, -1);
    total++;
    if (beats.size() != 4 || first_v != 2 || done_c != 6) begin
      bad++;
      $display("FAIL abort_restart got beats=%0d first_v=%0d done_c=%0d want 4 2 6", beats.size(), first_v, done_c);
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (beats[k] !== {e[k], 4'b1111, k == 3}) begin bad++; $display("FAIL abort_beat[%0d] got %h want %h", k, beats[k], {e[k], 4'b1111, k == 3}); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sram[i] = '0;
    test_reset();
    test_basic();
    test_tiles();
    test_quant();
    test_backpressure();
    test_empty_and_ignore();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
